// File: rtl/led_scan_sequencer.sv
// Scanning-head LED sequencer: a prescaled step counter moves a head across eight
// LEDs (bounce or wrap) and leaves a two-step fading trail on the per-LED duty buses.
module led_scan_sequencer #(
  parameter int unsigned STEP_DIV  = 5_000_000,
  parameter logic [7:0]  DUTY_HEAD = 8'd255,
  parameter logic [7:0]  DUTY_T1   = 8'd25,
  parameter logic [7:0]  DUTY_T2   = 8'd13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  output logic [63:0] duty,
  output logic [2:0]  position,
  output logic        direction,
  output logic        step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_t;

  localparam logic [31:0] PRE_LAST = 32'(STEP_DIV - 1);

  state_t      state_reg, state_next;
  logic [31:0] pre_reg, pre_next;
  logic [2:0]  head_reg, head_next;
  logic [2:0]  h1_reg, h1_next;
  logic [2:0]  h2_reg, h2_next;
  logic        v1_reg, v1_next;
  logic        v2_reg, v2_next;
  logic [63:0] duty_reg, duty_next;
  logic        dir_reg, dir_next;
  logic        step_reg, step_next;
  logic        run_next;
  logic [7:0]  lane_duty [8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pre_reg   <= '0;
      head_reg  <= '0;
      h1_reg    <= '0;
      h2_reg    <= '0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      duty_reg  <= '0;
      dir_reg   <= 1'b0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      head_reg  <= head_next;
      h1_reg    <= h1_next;
      h2_reg    <= h2_next;
      v1_reg    <= v1_next;
      v2_reg    <= v2_next;
      duty_reg  <= duty_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    head_next  = head_reg;
    h1_next    = h1_reg;
    h2_next    = h2_reg;
    v1_next    = v1_reg;
    v2_next    = v2_reg;
    step_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        pre_next  = '0;
        head_next = '0;
        h1_next   = '0;
        h2_next   = '0;
        v1_next   = 1'b0;
        v2_next   = 1'b0;
        if (enable) begin
          state_next = FWD;
        end
      end

      FWD, REV: begin
        if (!enable) begin
          // Disable wins over a coincident terminal count: no step is taken.
          state_next = IDLE;
          pre_next   = '0;
          head_next  = '0;
          h1_next    = '0;
          h2_next    = '0;
          v1_next    = 1'b0;
          v2_next    = 1'b0;
        end else if (pre_reg == PRE_LAST) begin
          pre_next  = '0;
          step_next = 1'b1;
          h2_next   = h1_reg;
          h1_next   = head_reg;
          v2_next   = v1_reg;
          v1_next   = 1'b1;
          if (mode) begin
            // Wrap always advances, even if we were descending.
            state_next = FWD;
            head_next  = head_reg + 3'd1;
          end else if (state_reg == FWD) begin
            if (head_reg == 3'd7) begin
              head_next  = 3'd6;
              state_next = REV;
            end else begin
              head_next = head_reg + 3'd1;
            end
          end else begin
            if (head_reg == 3'd0) begin
              head_next  = 3'd1;
              state_next = FWD;
            end else begin
              head_next = head_reg - 3'd1;
            end
          end
        end else begin
          pre_next = pre_reg + 32'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign run_next = (state_next != IDLE);
  assign dir_next = (state_next == REV);

  // Duty lanes are derived from next-state values so duty and position update together.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    localparam logic [2:0] LED = 3'(gi);
    assign lane_duty[gi] = !run_next                   ? 8'd0 :
                           (head_next == LED)          ? DUTY_HEAD :
                           (v1_next && h1_next == LED) ? DUTY_T1 :
                           (v2_next && h2_next == LED) ? DUTY_T2 :
                                                         8'd0;
  end

  always_comb begin
    duty_next = '0;
    for (int i = 0; i < 8; i++) begin
      duty_next[8*i +: 8] = lane_duty[i];
    end
  end

  assign duty      = duty_reg;
  assign position  = head_reg;
  assign direction = dir_reg;
  assign step      = step_reg;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: scenario tasks plus randomized enable/mode activity,
// all checked against a step-level behavioural model of the scanner.
module tb_led_scan_sequencer;

  localparam int DIV = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [63:0] duty;
  logic [2:0]  position;
  logic        direction;
  logic        step;

  int tests = 0;
  int fails = 0;

  // Behavioural model: running flag, cycle count within a step, head, sweep
  // direction and a queue of previous heads (most recent first).
  logic m_run;
  logic m_desc;
  logic m_step;
  int   m_cnt;
  int   m_head;
  int   m_trail[$];

  led_scan_sequencer #(
    .STEP_DIV (DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .duty      (duty),
    .position  (position),
    .direction (direction),
    .step      (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    m_run  = 1'b0;
    m_desc = 1'b0;
    m_step = 1'b0;
    m_cnt  = 0;
    m_head = 0;
    m_trail.delete();
  endtask

  task automatic model_step();
    int nxt;
    m_step = 1'b0;
    if (!m_run) begin
      if (enable) begin
        m_run  = 1'b1;
        m_head = 0;
        m_desc = 1'b0;
        m_cnt  = 0;
        m_trail.delete();
      end
    end else if (!enable) begin
      model_clear();
    end else if (m_cnt == DIV - 1) begin
      m_cnt  = 0;
      m_step = 1'b1;
      m_trail.push_front(m_head);
      if (m_trail.size() > 2) void'(m_trail.pop_back());
      if (mode) begin
        m_head = (m_head + 1) % 8;
        m_desc = 1'b0;
      end else begin
        nxt = m_desc ? m_head - 1 : m_head + 1;
        if (nxt > 7) begin
          nxt    = 6;
          m_desc = 1'b1;
        end else if (nxt < 0) begin
          nxt    = 1;
          m_desc = 1'b0;
        end
        m_head = nxt;
      end
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [63:0] exp_duty();
    logic [63:0] d;
    d = '0;
    if (m_run) begin
      for (int i = 0; i < 8; i++) begin
        if (i == m_head) d[8*i +: 8] = 8'd255;
        else if (m_trail.size() > 0 && m_trail[0] == i) d[8*i +: 8] = 8'd25;
        else if (m_trail.size() > 1 && m_trail[1] == i) d[8*i +: 8] = 8'd13;
      end
    end
    return d;
  endfunction

  function automatic logic [68:0] exp_vec();
    return {m_step, m_desc, 3'(m_head), exp_duty()};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) model_clear();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    mode   = 1'b0;
    model_clear();
    repeat (2) tick();
    tests++;
    if ({step, direction, position, duty} !== 69'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {step, direction, position, duty});
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    tests++;
    if (duty !== 64'h00000000000000FF) begin
      fails++;
      $display("FAIL reset_entry_duty: got %h expected 00000000000000ff", duty);
    end
    for (int c = 1; c <= DIV; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL reset_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
    end
    tests++;
    if (step !== 1'b1 || position !== 3'd1 || duty !== 64'h000000000000FF19) begin
      fails++;
      $display("FAIL reset_first_step: got step=%0b pos=%0d duty=%h expected step=1 pos=1 duty=000000000000ff19",
               step, position, duty);
    end
  endtask

  task automatic test_forward();
    for (int c = 0; c < 2 * DIV; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL forward_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
      if (m_step && m_head == 2) begin
        tests++;
        if (duty !== 64'h0000000000FF190D) begin
          fails++;
          $display("FAIL forward_step2: got %h expected 0000000000ff190d", duty);
        end
      end
      if (m_step && m_head == 3) begin
        tests++;
        if (duty !== 64'h00000000FF190D00) begin
          fails++;
          $display("FAIL forward_step3: got %h expected 00000000ff190d00", duty);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic seen_top;
    logic seen_bottom;
    seen_top    = 1'b0;
    seen_bottom = 1'b0;
    for (int c = 0; c < 200 && !seen_bottom; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL bounce_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
      if (m_step && m_trail[0] == 7) begin
        seen_top = 1'b1;
        tests++;
        if (position !== 3'd6 || direction !== 1'b1 || duty !== 64'h19FF000000000000) begin
          fails++;
          $display("FAIL bounce_top: got pos=%0d dir=%0b duty=%h expected pos=6 dir=1 duty=19ff000000000000",
                   position, direction, duty);
        end
      end
      if (seen_top && m_step && m_trail[0] == 0) begin
        seen_bottom = 1'b1;
        tests++;
        if (position !== 3'd1 || direction !== 1'b0) begin
          fails++;
          $display("FAIL bounce_bottom: got pos=%0d dir=%0b expected pos=1 dir=0", position, direction);
        end
      end
    end
    tests++;
    if (!seen_bottom) begin
      fails++;
      $display("FAIL bounce_timeout: got top=%0b bottom=%0b expected both 1", seen_top, seen_bottom);
    end
  endtask

  task automatic test_wrap();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (m_step && m_desc && m_head == 4) found = 1'b1;
    end
    tests++;
    if (!found || position !== 3'd4 || direction !== 1'b1) begin
      fails++;
      $display("FAIL wrap_setup: got found=%0b pos=%0d dir=%0b expected found=1 pos=4 dir=1", found, position, direction);
    end
    mode = 1'b1;
    for (int c = 0; c < DIV; c++) tick();
    tests++;
    if (step !== 1'b1 || position !== 3'd5 || direction !== 1'b0) begin
      fails++;
      $display("FAIL wrap_switch: got step=%0b pos=%0d dir=%0b expected step=1 pos=5 dir=0", step, position, direction);
    end
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL wrap_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
      if (m_step && m_trail[0] == 7) found = 1'b1;
    end
    tests++;
    if (!found || position !== 3'd0 || duty !== 64'h190D0000000000FF) begin
      fails++;
      $display("FAIL wrap_roll: got found=%0b pos=%0d duty=%h expected found=1 pos=0 duty=190d0000000000ff",
               found, position, duty);
    end
    mode = 1'b0;
  endtask

  task automatic test_disable();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (m_run && m_cnt == DIV - 1) found = 1'b1;
    end
    enable = 1'b0;
    tick();
    tests++;
    if (!found || step !== 1'b0 || duty !== 64'd0 || position !== 3'd0) begin
      fails++;
      $display("FAIL disable_terminal: got found=%0b step=%0b pos=%0d duty=%h expected found=1 step=0 pos=0 duty=0",
               found, step, position, duty);
    end
    enable = 1'b1;
    tick();
    tests++;
    if (duty !== 64'h00000000000000FF || step !== 1'b0) begin
      fails++;
      $display("FAIL disable_reenable: got step=%0b duty=%h expected step=0 duty=00000000000000ff", step, duty);
    end
    for (int c = 0; c < 3 * DIV; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL disable_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 4) mode = ~mode;
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL random_model c=%0d en=%0b mode=%0b: got %h expected %h",
                 c, enable, mode, {step, direction, position, duty}, exp_vec());
      end
    end
    enable = 1'b1;
    mode   = 1'b0;
  endtask

  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      tick();
      if (m_step && m_head == 5) found = 1'b1;
    end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    tests++;
    if (!found || {step, direction, position, duty} !== 69'd0) begin
      fails++;
      $display("FAIL async_reset_clear: got found=%0b outputs=%h expected found=1 outputs=0",
               found, {step, direction, position, duty});
    end
    #2;
    reset = 1'b0;
    tick();
    tests++;
    if (duty !== 64'h00000000000000FF || position !== 3'd0) begin
      fails++;
      $display("FAIL async_reset_restart: got pos=%0d duty=%h expected pos=0 duty=00000000000000ff", position, duty);
    end
    for (int c = 0; c < 2 * DIV; c++) begin
      tick();
      tests++;
      if ({step, direction, position, duty} !== exp_vec()) begin
        fails++;
        $display("FAIL async_reset_model c=%0d: got %h expected %h", c, {step, direction, position, duty}, exp_vec());
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 1'b0;
    test_reset();
    test_forward();
    test_bounce();
    test_wrap();
    test_disable();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
